// File: rtl/video_stream_gen_pkg.sv
// Shared types and constants for the video test-pattern source.
// Holds the colour set, pattern encodings, latched config struct and timing totals.
package video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    PAT_RECT  = 2'd0,
    PAT_WHITE = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_RAMP  = 2'd3
  } pat_sel_t;

  typedef struct packed {
    pat_sel_t   pat;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] y0;
    logic [7:0] y1;
  } cfg_t;

  localparam pixel_t WHITE   = 24'hFFFFFF;
  localparam pixel_t YELLOW  = 24'hFFFF00;
  localparam pixel_t CYAN    = 24'h00FFFF;
  localparam pixel_t GREEN   = 24'h00FF00;
  localparam pixel_t MAGENTA = 24'hFF00FF;
  localparam pixel_t RED     = 24'hFF0000;
  localparam pixel_t BLUE    = 24'h0000FF;
  localparam pixel_t BLACK   = 24'h000000;

  function automatic int h_total(input int sync, input int bp, input int img, input int fp);
    return sync + bp + img + fp;
  endfunction

  function automatic int v_total(input int sync, input int bp, input int img, input int fp);
    return sync + bp + img + fp;
  endfunction

endpackage

// File: rtl/video_stream_gen_if.sv
// Pixel stream bundle: syncs, data enable and RGB888 pixel.
// The generator drives it as master; the downstream detector consumes it as slave.
interface video_stream_gen_if;
  import video_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   de;
  pixel_t pixel;

  modport master (output hsync, vsync, de, pixel);
  modport slave  (input  hsync, vsync, de, pixel);
endinterface

// File: rtl/video_stream_gen_pattern.sv
// Combinational test-pattern mux: active-pixel x/y plus latched config -> RGB888.
// Out-of-range x/y produce don't-care colours; the caller masks them with de.
module video_pattern
  import video_pkg::*;
#(
  parameter int IMG_W = 200
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  cfg_t        i_cfg,
  output pixel_t      o_pixel
);

  logic        w_in_rect;
  logic [31:0] w_bar;
  pixel_t      w_bar_col;

  // x0 > x1 or y0 > y1 makes one of the ranges empty, so the image is all white
  assign w_in_rect = (i_x >= {4'd0, i_cfg.x0}) && (i_x <= {4'd0, i_cfg.x1}) &&
                     (i_y >= {4'd0, i_cfg.y0}) && (i_y <= {4'd0, i_cfg.y1});

  assign w_bar = ({20'd0, i_x} << 3) / 32'(IMG_W);

  always_comb begin
    w_bar_col = BLACK;
    case (w_bar)
      32'd0:   w_bar_col = WHITE;
      32'd1:   w_bar_col = YELLOW;
      32'd2:   w_bar_col = CYAN;
      32'd3:   w_bar_col = GREEN;
      32'd4:   w_bar_col = MAGENTA;
      32'd5:   w_bar_col = RED;
      32'd6:   w_bar_col = BLUE;
      default: w_bar_col = BLACK;
    endcase
  end

  always_comb begin
    o_pixel = WHITE;
    case (i_cfg.pat)
      PAT_RECT:  o_pixel = w_in_rect ? BLACK : WHITE;
      PAT_WHITE: o_pixel = WHITE;
      PAT_BARS:  o_pixel = w_bar_col;
      PAT_RAMP:  o_pixel = {3{i_x[7:0]}};
      default:   o_pixel = WHITE;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// Frame-timing generator with registered sync/de/pixel outputs and a test-pattern source.
// state  | meaning
// S_IDLE | counters parked at 0, outputs inactive, waiting for i_en
// S_RUN  | scanning frames; leaves only at the last cycle of a frame with i_en low
module video_stream_gen
  import video_pkg::*;
#(
  parameter int IMG_W    = 200,
  parameter int IMG_H    = 164,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 4,
  parameter int H_FP     = 4,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int V_FP     = 2,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [1:0]                i_pat_sel,
  input  logic [7:0]                i_rect_x0,
  input  logic [7:0]                i_rect_x1,
  input  logic [7:0]                i_rect_y0,
  input  logic [7:0]                i_rect_y1,
  video_stream_gen_if.master        vid,
  output logic                      o_frame_start,
  output logic                      o_busy
);

  localparam int H_TOTAL = h_total(H_SYNC, H_BP, IMG_W, H_FP);
  localparam int V_TOTAL = v_total(V_SYNC, V_BP, IMG_H, V_FP);

  generate
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
      $error("video_stream_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end
  endgenerate

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_SYNC_E  = 13'(H_SYNC);
  localparam logic [12:0] V_SYNC_E  = 13'(V_SYNC);
  localparam logic [12:0] H_ACT_BEG = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_ACT_END = 13'(H_SYNC + H_BP + IMG_W);
  localparam logic [12:0] V_ACT_BEG = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_ACT_END = 13'(V_SYNC + V_BP + IMG_H);
  localparam logic [11:0] X_OFS     = 12'(H_SYNC + H_BP);
  localparam logic [11:0] Y_OFS     = 12'(V_SYNC + V_BP);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [11:0] r_h;
  logic [11:0] r_v;
  cfg_t        r_cfg;

  cfg_t        w_cfg_in;
  logic        w_run;
  logic        w_h_last;
  logic        w_v_last;
  logic [12:0] w_h;
  logic [12:0] w_v;
  logic        w_hs;
  logic        w_vs;
  logic        w_de;
  logic        w_fs;
  logic [11:0] w_x;
  logic [11:0] w_y;
  pixel_t      w_pix;

  always_comb begin
    w_cfg_in     = '0;
    w_cfg_in.pat = pat_sel_t'(i_pat_sel);
    w_cfg_in.x0  = i_rect_x0;
    w_cfg_in.x1  = i_rect_x1;
    w_cfg_in.y0  = i_rect_y0;
    w_cfg_in.y1  = i_rect_y1;
  end

  assign w_run    = (r_state == S_RUN);
  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  // Config is captured only at frame boundaries so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_cfg   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_h <= '0;
          r_v <= '0;
          if (i_en) begin
            r_state <= S_RUN;
            r_cfg   <= w_cfg_in;
          end
        end
        S_RUN: begin
          if (w_h_last) begin
            r_h <= '0;
            if (w_v_last) begin
              r_v   <= '0;
              r_cfg <= w_cfg_in;
              if (!i_en) r_state <= S_IDLE;
            end else begin
              r_v <= r_v + 12'd1;
            end
          end else begin
            r_h <= r_h + 12'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_h  = {1'b0, r_h};
  assign w_v  = {1'b0, r_v};
  assign w_hs = w_run && (w_h < H_SYNC_E);
  assign w_vs = w_run && (w_v < V_SYNC_E);
  assign w_de = w_run && (w_h >= H_ACT_BEG) && (w_h < H_ACT_END) &&
                (w_v >= V_ACT_BEG) && (w_v < V_ACT_END);
  assign w_fs = w_run && (r_h == 12'd0) && (r_v == 12'd0);
  assign w_x  = r_h - X_OFS;
  assign w_y  = r_v - Y_OFS;

  video_pattern #(
    .IMG_W (IMG_W)
  ) u_pattern (
    .i_x     (w_x),
    .i_y     (w_y),
    .i_cfg   (r_cfg),
    .o_pixel (w_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.hsync     <= ~SYNC_POL;
      vid.vsync     <= ~SYNC_POL;
      vid.de        <= 1'b0;
      vid.pixel     <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      vid.hsync     <= w_hs ? SYNC_POL : ~SYNC_POL;
      vid.vsync     <= w_vs ? SYNC_POL : ~SYNC_POL;
      vid.de        <= w_de;
      vid.pixel     <= w_de ? w_pix : '0;
      o_frame_start <= w_fs;
      o_busy        <= w_run;
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen at default timing (212 x 170 clocks per frame).
// Outputs are sampled on the falling edge; k counts output cycles from the frame_start sample.
module tb_video_stream_gen;
  import video_pkg::*;

  localparam int HT    = 212;
  localparam int VT    = 170;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_en;
  logic [1:0] i_pat_sel;
  logic [7:0] i_rect_x0, i_rect_x1, i_rect_y0, i_rect_y1;
  logic       o_frame_start, o_busy;

  video_stream_gen_if vif ();

  video_stream_gen dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .i_pat_sel     (i_pat_sel),
    .i_rect_x0     (i_rect_x0),
    .i_rect_x1     (i_rect_x1),
    .i_rect_y0     (i_rect_y0),
    .i_rect_y1     (i_rect_y1),
    .vid           (vif),
    .o_frame_start (o_frame_start),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int de_cnt, blk_cnt, wht_cnt, de_lines, min_blk_x, vs_cnt;
  int hs_err, vs_err, de_err, idle_px_err, fs_cnt, busy_lo;
  int e_de, e_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scans one whole frame starting at its frame_start sample; returns on its last cycle.
  task automatic scan_frame(input int chg_k, input int drop_k);
    int h, v, line_de;
    de_cnt = 0; blk_cnt = 0; wht_cnt = 0; de_lines = 0; min_blk_x = 9999; vs_cnt = 0;
    hs_err = 0; vs_err = 0; de_err = 0; idle_px_err = 0; fs_cnt = 0; busy_lo = 0;
    line_de = 0;
    for (int k = 0; k < FRAME; k++) begin
      h = k % HT;
      v = k / HT;
      if (k == chg_k)  i_rect_x0 = 8'd60;
      if (k == drop_k) i_en = 1'b0;
      if (h == 0) line_de = 0;
      if (vif.de) begin
        de_cnt++;
        line_de++;
        if (vif.pixel === 24'h000000) begin
          blk_cnt++;
          if (h - 8 < min_blk_x) min_blk_x = h - 8;
        end
        if (vif.pixel === 24'hFFFFFF) wht_cnt++;
      end else if (vif.pixel !== 24'h000000) begin
        idle_px_err++;
      end
      if (h == HT - 1 && line_de != 0) de_lines++;
      if (vif.hsync !== (h < 4)) hs_err++;
      if (vif.vsync !== (v < 2)) vs_err++;
      if (vif.de !== (h >= 8 && h < 208 && v >= 4 && v < 168)) de_err++;
      if (vif.vsync === 1'b1) vs_cnt++;
      if (o_frame_start === 1'b1) fs_cnt++;
      if (o_busy !== 1'b1) busy_lo++;
      if (k != FRAME - 1) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_en = 1'b0; i_pat_sel = 2'd0;
    i_rect_x0 = 8'd50; i_rect_x1 = 8'd120; i_rect_y0 = 8'd40; i_rect_y1 = 8'd100;
    adv(3);
    chk("rst_hsync", vif.hsync, 1'b0);
    chk("rst_vsync", vif.vsync, 1'b0);
    chk("rst_de", vif.de, 1'b0);
    chk("rst_pixel", vif.pixel, 24'h0);
    chk("rst_fs", o_frame_start, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    adv(3);
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_hsync", vif.hsync, 1'b0);

    // Frame A: rectangle, x0 moved to 60 on line 30 must not affect this frame
    i_en = 1'b1;
    adv(1);
    chk("fs_latency_early", o_frame_start, 1'b0);
    adv(1);
    chk("fs_first", o_frame_start, 1'b1);
    scan_frame(30 * HT + 5, -1);
    chk("a_de_cnt", de_cnt, 32800);
    chk("a_de_lines", de_lines, 164);
    chk("a_black", blk_cnt, 4331);
    chk("a_white", wht_cnt, 28469);
    chk("a_edge_x", min_blk_x, 50);
    chk("a_vsync_cycles", vs_cnt, 424);
    chk("a_hsync_err", hs_err, 0);
    chk("a_vsync_err", vs_err, 0);
    chk("a_de_err", de_err, 0);
    chk("a_idle_px", idle_px_err, 0);
    chk("a_fs_cnt", fs_cnt, 1);
    chk("a_busy_lo", busy_lo, 0);

    // Frame B: new x0 takes effect; i_en dropped at line 80 still finishes the frame
    adv(1);
    chk("fs_period", o_frame_start, 1'b1);
    scan_frame(-1, 80 * HT);
    chk("b_edge_x", min_blk_x, 60);
    chk("b_black", blk_cnt, 3721);
    chk("b_de_lines", de_lines, 164);
    chk("b_de_err", de_err, 0);
    chk("b_busy_lo", busy_lo, 0);
    chk("b_fs_cnt", fs_cnt, 1);
    adv(1);
    chk("end_busy", o_busy, 1'b0);
    chk("end_hsync", vif.hsync, 1'b0);
    chk("end_vsync", vif.vsync, 1'b0);
    chk("end_de", vif.de, 1'b0);
    adv(5);
    chk("end_no_restart_busy", o_busy, 1'b0);
    chk("end_no_restart_fs", o_frame_start, 1'b0);

    // Colour bars, then asynchronous reset at line 30
    i_pat_sel = 2'd2;
    i_en = 1'b1;
    adv(2);
    chk("c_fs", o_frame_start, 1'b1);
    adv(4 * HT + 8);
    chk("bars_de_x0", vif.de, 1'b1);
    chk("bars_x0", vif.pixel, 24'hFFFFFF);
    adv(100);
    chk("bars_x100", vif.pixel, 24'hFF00FF);
    adv(99);
    chk("bars_x199", vif.pixel, 24'h000000);
    adv(30 * HT + 2 - (4 * HT + 8 + 199));
    chk("pre_rst_hsync", vif.hsync, 1'b1);
    chk("pre_rst_busy", o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hsync", vif.hsync, 1'b0);
    chk("async_rst_busy", o_busy, 1'b0);
    chk("async_rst_de", vif.de, 1'b0);
    chk("async_rst_pixel", vif.pixel, 24'h0);

    // Restart after reset with an empty rectangle
    i_pat_sel = 2'd0; i_rect_x0 = 8'd120; i_rect_x1 = 8'd50;
    adv(1);
    rst_n = 1'b1;
    adv(1);
    chk("restart_vsync_early", vif.vsync, 1'b0);
    adv(1);
    chk("restart_vsync", vif.vsync, 1'b1);
    chk("restart_fs", o_frame_start, 1'b1);
    e_de = 0; e_bad = 0;
    for (int k = 0; k < 46 * HT; k++) begin
      if (vif.de === 1'b1) begin
        e_de++;
        if (vif.pixel !== 24'hFFFFFF) e_bad++;
      end
      @(negedge clk);
    end
    chk("empty_de_cnt", e_de, 8400);
    chk("empty_non_white", e_bad, 0);

    // Grey ramp
    rst_n = 1'b0;
    i_pat_sel = 2'd3;
    adv(1);
    rst_n = 1'b1;
    adv(2);
    chk("ramp_fs", o_frame_start, 1'b1);
    adv(4 * HT + 8);
    chk("ramp_de", vif.de, 1'b1);
    chk("ramp_x0", vif.pixel, 24'h000000);
    adv(100);
    chk("ramp_x100", vif.pixel, 24'h646464);
    adv(99);
    chk("ramp_x199", vif.pixel, 24'hC7C7C7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
